add16_arbiter: RTL and testbench
================================

ADD16_ARBITER -- requirements
Module: add16_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters, legal range 2..8.
REQ-002 Parameter IDW, default 2, requester-index width, SHALL equal clog2(NREQ).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept, at most one bit set (one-hot or zero).
REQ-007 req_a  input  16*NREQ  operand A, requester i in bits [16i+15:16i].
REQ-008 req_b  input  16*NREQ  operand B, same packing as req_a.
REQ-009 req_cin  input  NREQ  carry-in per requester.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  result consumer accept.
REQ-012 rsp_id  output  IDW  index of the requester that owns the result.
REQ-013 rsp_y  output  16  sum.
REQ-014 rsp_co  output  1  carry-out.

Function
REQ-015 Sum SHALL be computed by one shared adder_16bit instance; rsp_y = (a+b+cin) mod 2^16, rsp_co = bit 16 of the same sum.
REQ-016 FSM states: IDLE, CALC, RESP; no other states reachable.
REQ-017 IDLE: if any req_valid set, req_ready SHALL be asserted combinationally for the round-robin winner only; else req_ready = 0 and the FSM stays in IDLE.
REQ-018 Handshake = req_valid[i] & req_ready[i]. On the handshake edge, a/b/cin/id of the winner are latched and the FSM goes IDLE->CALC.
REQ-019 CALC: lasts exactly one cycle. The adder result is registered into rsp_y/rsp_co/rsp_id. The FSM goes ->RESP and rsp_valid rises.
REQ-020 Latency: handshake at edge t; rsp_valid SHALL be 1 from edge t+2.
REQ-021 RESP: rsp_valid = 1 and rsp_y/rsp_co/rsp_id are held stable until rsp_valid & rsp_ready; on that edge the FSM goes ->IDLE and rsp_valid falls.
REQ-022 rsp_ready high in the first RESP cycle SHALL complete the response in that cycle. Peak throughput is one operation per 3 cycles.
REQ-023 req_ready SHALL be 0 in CALC and RESP regardless of req_valid.
REQ-024 Round-robin: the priority pointer starts at index 0. After a grant to i, the pointer becomes (i+1) mod NREQ and the search proceeds upward with wrap-around.
REQ-025 The pointer SHALL update only on a handshake; idle cycles leave it unchanged.
REQ-026 Deasserting req_valid before a handshake SHALL have no side effect. The winner is re-evaluated every IDLE cycle.

Reset
REQ-027 When rst=1 at a clock edge: state = IDLE, pointer = 0, rsp_valid = 0, rsp_y = 0, rsp_co = 0, rsp_id = 0, latched operands = 0.
REQ-028 Reset in CALC or RESP SHALL discard the transaction with no response.
REQ-029 req_ready SHALL be 0 during any cycle with rst=1.

Configuration
REQ-030 Macro ADD16_ARB_OVF_EN defined: adds output port rsp_ovf (1 bit), the signed two's-complement overflow = (a[15]==b[15]) & (rsp_y[15]!=a[15]). It is registered with rsp_y, reset to 0, and held in RESP.
REQ-031 ADD16_ARB_OVF_EN undefined: rsp_ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Single request: req 0, a=16'h00FF, b=16'h0001, cin=0 -> rsp_valid at t+2 with rsp_y=16'h0100, co=0, id=0.
REQ-033 Carry/wrap: a=16'hFFFF, b=16'h0000, cin=1 -> rsp_y=16'h0000, co=1.
REQ-034 All 4 requesters valid continuously from reset, rsp_ready=1 -> grant order 0,1,2,3,0 with one grant every 3 cycles.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; completes on the first rsp_ready=1 edge.
REQ-036 rst pulsed in CALC -> no rsp_valid; next request is granted to index 0 with pointer reset.
REQ-037 With ADD16_ARB_OVF_EN: a=16'h7FFF, b=16'h0001 -> rsp_y=16'h8000, rsp_ovf=1, co=0.

Source files
------------

// File: rtl/add16_arbiter.sv
// add16_arbiter: round-robin arbiter sharing one 16-bit adder among NREQ requesters.
// Define ADD16_ARB_OVF_EN to add the registered signed-overflow output rsp_ovf.

module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] y,
  output logic        co
);
  assign {co, y} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

module add16_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2  // must equal $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_y,
  output logic                 rsp_co
`ifdef ADD16_ARB_OVF_EN
  ,
  output logic                 rsp_ovf
`endif
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    a_q, b_q;
  logic           cin_q;
  logic [IDW-1:0] id_q;
  logic [15:0]    rsp_y_q;
  logic           rsp_co_q;
  logic [IDW-1:0] rsp_id_q;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   cand;
  logic           hs;
  logic [15:0]    sum_y;
  logic           sum_co;

  // Search upward from the pointer with wrap-around; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  assign req_ready = (!rst && state_q == StIdle && win_found) ?
                     ({{(NREQ-1){1'b0}}, 1'b1} << win_id) : '0;
  assign hs = |(req_valid & req_ready);

  adder_16bit u_adder (
    .a   (a_q),
    .b   (b_q),
    .cin (cin_q),
    .y   (sum_y),
    .co  (sum_co)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (hs) begin
          state_d = StCalc;
          ptr_d   = (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
        end
      end
      StCalc:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef ADD16_ARB_OVF_EN
  logic rsp_ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_ovf_q <= 1'b0;
    end else if (state_q == StCalc) begin
      rsp_ovf_q <= (a_q[15] == b_q[15]) & (sum_y[15] != a_q[15]);
    end
  end
  assign rsp_ovf = rsp_ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      id_q     <= '0;
      rsp_y_q  <= '0;
      rsp_co_q <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == StIdle && hs) begin
        a_q   <= req_a[16*win_id +: 16];
        b_q   <= req_b[16*win_id +: 16];
        cin_q <= req_cin[win_id];
        id_q  <= win_id;
      end
      if (state_q == StCalc) begin
        rsp_y_q  <= sum_y;
        rsp_co_q <= sum_co;
        rsp_id_q <= id_q;
      end
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_y     = rsp_y_q;
  assign rsp_co    = rsp_co_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_add16_arbiter.sv
// tb_add16_arbiter: scoreboard bench for add16_arbiter with a cycle-level reference model.
// Compile with ADD16_ARB_OVF_EN defined to also check rsp_ovf.

module tb_add16_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [NREQ-1:0] req_cin;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     rsp_y;
  logic            rsp_co;
`ifdef ADD16_ARB_OVF_EN
  logic            rsp_ovf;
`endif

  add16_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_co    (rsp_co)
`ifdef ADD16_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    y;
    logic           co;
    logic           ovf;
    int             hs;
  } exp_t;

  exp_t sb[$];

  // Reference model: who should be granted, when the response is due, and what it holds.
  int m_ptr   = 0;
  bit m_busy  = 1'b0;
  int m_vfrom = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_ptr  = 0;
      m_busy = 1'b0;
      check("req_ready_in_rst", 32'(req_ready), 0);
    end else begin : model
      bit   exp_v;
      int   w;
      exp_t e;
      logic [15:0] a, b;
      logic [16:0] s;
      exp_v = m_busy && (cyc + 1 >= m_vfrom);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (!m_busy) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        check("req_ready_grant", 32'(req_ready), (w < 0) ? 0 : (1 << w));
        if (w >= 0) begin
          a = req_a[16*w +: 16];
          b = req_b[16*w +: 16];
          s = {1'b0, a} + {1'b0, b} + 17'(req_cin[w]);
          e.id  = IDW'(w);
          e.y   = s[15:0];
          e.co  = s[16];
          e.ovf = (a[15] == b[15]) && (s[15] != a[15]);
          e.hs  = cyc + 1;
          sb.push_back(e);
          m_ptr   = (w + 1) % NREQ;
          m_busy  = 1'b1;
          m_vfrom = cyc + 3;
        end
      end else begin
        check("req_ready_busy", 32'(req_ready), 0);
        if (exp_v && rsp_ready) m_busy = 1'b0;
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 id=%0d y=%h, required no response",
                   rsp_id, rsp_y);
        end else begin
          check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          check("rsp_y", 32'(rsp_y), 32'(sb[0].y));
          check("rsp_co", 32'(rsp_co), 32'(sb[0].co));
`ifdef ADD16_ARB_OVF_EN
          check("rsp_ovf", 32'(rsp_ovf), 32'(sb[0].ovf));
`endif
          if (!prev_v) check("latency", 32'(cyc + 1 - sb[0].hs), 2);
          if (rsp_ready) void'(sb.pop_front());
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic c);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_cin[i]        = c;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL grant_timeout: requester %0d got no grant, required grant within 30", i);
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output logic [15:0] y, output logic co, output logic [IDW-1:0] id);
    bit got;
    got = 1'b0;
    y = '0;
    co = 1'b0;
    id = '0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        y   = rsp_y;
        co  = rsp_co;
        id  = rsp_id;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got no rsp_valid, required response within 30 cycles");
    end
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0]    y;
    logic           co;
    logic [IDW-1:0] id;
    int             g_id[$];
    int             g_cyc[$];
    int             exp_order[5];
    logic [NREQ-1:0] hs;
    int             gid;

    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_y", 32'(rsp_y), 0);
    check("rst_rsp_co", 32'(rsp_co), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    rst = 1'b0;

    // Single request on requester 0.
    set_req(0, 16'h00FF, 16'h0001, 1'b0);
    wait_grant(0);
    wait_rsp(y, co, id);
    check("single_y", 32'(y), 32'h0100);
    check("single_co", 32'(co), 0);
    check("single_id", 32'(id), 0);
    @(posedge clk);
    #1;

    // Carry out and wrap; pointer is at 1 so requester 2 is found by upward search.
    set_req(2, 16'hFFFF, 16'h0000, 1'b1);
    wait_grant(2);
    wait_rsp(y, co, id);
    check("wrap_y", 32'(y), 32'h0000);
    check("wrap_co", 32'(co), 1);
    check("wrap_id", 32'(id), 2);
    @(posedge clk);
    #1;

`ifdef ADD16_ARB_OVF_EN
    set_req(3, 16'h7FFF, 16'h0001, 1'b0);
    wait_grant(3);
    wait_rsp(y, co, id);
    check("ovf_y", 32'(y), 32'h8000);
    check("ovf_co", 32'(co), 0);
    check("ovf_flag", 32'(rsp_ovf), 1);
    @(posedge clk);
    #1;
`endif

    // Backpressure: hold rsp_ready low while another requester waits.
    rsp_ready = 1'b0;
    set_req(1, rand16(), rand16(), 1'($urandom));
    wait_grant(1);
    set_req(0, rand16(), rand16(), 1'($urandom));
    wait_rsp(y, co, id);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_done", 32'(rsp_valid), 0);
    wait_grant(0);
    repeat (4) @(posedge clk);
    #1;

    // All requesters valid from reset, consumer always ready.
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, rand16(), rand16(), 1'($urandom));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        gid = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        g_id.push_back(gid);
        g_cyc.push_back(cyc);
      end
    end
    check("rr_count", 32'(g_id.size() >= 5), 1);
    for (int k = 0; k < 5 && k < g_id.size(); k++) begin
      check("rr_order", 32'(g_id[k]), 32'(exp_order[k]));
      if (k > 0) check("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 3);
    end
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;

    // Reset during CALC drops the transaction and returns the pointer to 0.
    set_req(2, rand16(), rand16(), 1'($urandom));
    wait_grant(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("rst_calc_no_rsp", 32'(rsp_valid), 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) set_req(i, rand16(), rand16(), 1'($urandom));
    @(negedge clk);
    check("post_rst_grant", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;

    // Randomised traffic with early withdrawal and random backpressure.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] || $urandom_range(0, 7) == 0) begin
          req_valid[i]      = ($urandom_range(0, 3) != 0);
          req_a[16*i +: 16] = rand16();
          req_b[16*i +: 16] = rand16();
          req_cin[i]        = 1'($urandom);
        end
      end
    end

    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
